// File: rtl/i2c_slave_ctrl_if.sv
// Bus-side bundle for the I2C slave byte sequencer: raw lines, detector
// events, register-side byte handshakes and status.
interface i2c_slave_ctrl_if;
  logic       scl;
  logic       sda;
  logic       start;
  logic       stop;
  logic [7:0] tx_data;
  logic       det_enable;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addr_match;
  logic       busy;

  modport master (
    output scl, sda, start, stop, tx_data,
    input  det_enable, sda_oe, rx_data, rx_valid, tx_req, addr_match, busy
  );

  modport slave (
    input  scl, sda, start, stop, tx_data,
    output det_enable, sda_oe, rx_data, rx_valid, tx_req, addr_match, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte sequencer: tracks address/data/ACK phases from synchronised
// SCL/SDA, drives the SDA pull-down and handshakes bytes with the register side.
module i2c_slave_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  i2c_slave_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic [6:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rw_q, rw_d;
  logic                   pend_q, pend_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_req_q, tx_req_d;
  logic                   addr_match_q, addr_match_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, sda_oe;
  logic [7:0] shift_in;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_dly_d  = scl_s;
    scl_rise   = scl_s & ~scl_dly_q;
    scl_fall   = ~scl_s & scl_dly_q;
    shift_in   = {shift_q, sda_s};
  end

  // pend_q: in TX the 8th bit has been clocked; in TX_ACK the master ACKed.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rx_data_d    = rx_data_q;
    rw_d         = rw_q;
    pend_d       = pend_q;
    sda_oe_d     = sda_oe_q;
    addr_match_d = addr_match_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;

    unique case (state_q)
      S_ADDR: if (scl_rise) begin
        shift_d   = shift_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (shift_in[7:1] == SLAVE_ADDR) begin
            rw_d    = shift_in[0];
            state_d = S_ADDR_ACK;
          end else begin
            state_d = S_WAIT_STOP;
          end
        end
      end
      // sda_oe_q itself tells the first ACK-bit fall (assert) from the second (exit).
      S_ADDR_ACK: if (scl_fall) begin
        if (!sda_oe_q) begin
          sda_oe_d     = 1'b1;
          addr_match_d = 1'b1;
        end else if (rw_q) begin
          tx_req_d = 1'b1;
          state_d  = S_TX;
        end else begin
          sda_oe_d = 1'b0;
          state_d  = S_RX;
        end
      end
      S_RX: if (scl_rise) begin
        shift_d   = shift_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d  = shift_in;
          rx_valid_d = 1'b1;
          state_d    = S_RX_ACK;
        end
      end
      S_RX_ACK: if (scl_fall) begin
        sda_oe_d = ~sda_oe_q;
        if (sda_oe_q) state_d = S_RX;
      end
      S_TX: begin
        if (tx_req_q) begin
          shift_d  = bus.tx_data[6:0];
          sda_oe_d = ~bus.tx_data[7];
        end else if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) pend_d = 1'b1;
        end else if (scl_fall) begin
          if (pend_q) begin
            pend_d   = 1'b0;
            sda_oe_d = 1'b0;
            state_d  = S_TX_ACK;
          end else begin
            shift_d  = {shift_q[5:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      S_TX_ACK: begin
        if (scl_rise) begin
          if (sda_s) begin
            sda_oe_d = 1'b0;
            state_d  = S_WAIT_STOP;
          end else begin
            pend_d = 1'b1;
          end
        end else if (scl_fall && pend_q) begin
          pend_d   = 1'b0;
          tx_req_d = 1'b1;
          state_d  = S_TX;
        end
      end
      default: ;
    endcase

    // start is applied last so it overrides a coincident stop.
    if (bus.stop) begin
      state_d      = S_IDLE;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      pend_d       = 1'b0;
      tx_req_d     = 1'b0;
      rx_valid_d   = 1'b0;
    end
    if (bus.start) begin
      state_d      = S_ADDR;
      bit_cnt_d    = 3'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      pend_d       = 1'b0;
      tx_req_d     = 1'b0;
      rx_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // Sync stages reset to the idle-high bus level so no phantom edge follows reset.
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_dly_q    <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rx_data_q    <= '0;
      rw_q         <= 1'b0;
      pend_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      addr_match_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_dly_q    <= scl_dly_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_data_q    <= rx_data_d;
      rw_q         <= rw_d;
      pend_q       <= pend_d;
      sda_oe_q     <= sda_oe_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      addr_match_q <= addr_match_d;
    end
  end

  // In the tx_req cycle the first data bit comes straight from tx_data, which
  // is latched into shift_q at the end of that same cycle.
  assign sda_oe         = tx_req_q ? ~bus.tx_data[7] : sda_oe_q;
  assign bus.sda_oe     = sda_oe;
  assign bus.det_enable = ~rst & ~sda_oe;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.addr_match = addr_match_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: plays I2C master and start/stop detector,
// scoreboards received bytes and transmit loads.
module tb_i2c_slave_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic sda_m;

  int n_checks = 0;
  int n_fail   = 0;
  int oe_cycles = 0;
  int det_bad   = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  int rx_prev;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       oe;

  i2c_slave_ctrl_if bus ();

  assign bus.sda = sda_m & ~bus.sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Passive monitors sampled on the falling clock edge.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    logic       eb;
    if (!rst) begin
      if (bus.sda_oe) oe_cycles++;
      if (bus.det_enable !== ~bus.sda_oe) det_bad++;
      if (bus.rx_valid) begin
        rx_pulses++;
        n_checks++;
        assert (rx_q.size() != 0) else begin
          n_fail++;
          $error("FAIL rx_unexpected: observed rx_valid with data %0h, expected no pulse", bus.rx_data);
        end
        if (rx_q.size() != 0) begin
          e = rx_q.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e));
        end
      end
      if (bus.tx_req) begin
        tx_pulses++;
        n_checks++;
        assert (tx_q.size() != 0) else begin
          n_fail++;
          $error("FAIL tx_unexpected: observed tx_req, expected no pulse");
        end
        if (tx_q.size() != 0) begin
          e  = tx_q.pop_front();
          eb = ~e[7];
          check("tx_first_bit", 32'(bus.sda_oe), 32'(eb));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish within time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b0;
    wait_clk(2);
    bus.start = 1'b1;
    wait_clk(1);
    bus.start = 1'b0;
    wait_clk(8);
    bus.scl = 1'b0;
    wait_clk(10);
  endtask

  // Repeated start from the SCL-low phase; optional coincident stop pulse.
  task automatic bus_rstart(input logic with_stop, input string tag);
    sda_m = 1'b1;
    wait_clk(10);
    bus.scl = 1'b1;
    wait_clk(10);
    sda_m = 1'b0;
    bus.start = 1'b1;
    bus.stop  = with_stop;
    wait_clk(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_bit_cnt"}, 32'(dut.bit_cnt_q), 32'd0);
    check({tag, "_sda_oe"}, 32'(bus.sda_oe), 32'd0);
    check({tag, "_addr_match"}, 32'(bus.addr_match), 32'd0);
    wait_clk(9);
    bus.scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic bus_stop(input string tag);
    sda_m = 1'b0;
    wait_clk(10);
    bus.scl = 1'b1;
    wait_clk(10);
    sda_m = 1'b1;
    check({tag, "_busy_pre"}, 32'(bus.busy), 32'd1);
    bus.stop = 1'b1;
    wait_clk(1);
    bus.stop = 1'b0;
    check({tag, "_busy_post"}, 32'(bus.busy), 32'd0);
    check({tag, "_addr_match_post"}, 32'(bus.addr_match), 32'd0);
    check({tag, "_sda_oe_post"}, 32'(bus.sda_oe), 32'd0);
    wait_clk(20);
  endtask

  task automatic clk_bit(input logic b, output logic oe_hi);
    sda_m = b;
    wait_clk(10);
    bus.scl = 1'b1;
    wait_clk(10);
    oe_hi = bus.sda_oe;
    wait_clk(10);
    bus.scl = 1'b0;
    wait_clk(10);
  endtask

  // Master-driven bits: the slave must keep SDA released.
  task automatic send_bits(input logic [7:0] b, input int n, input string tag);
    logic o;
    for (int i = 7; i > 7 - n; i--) begin
      clk_bit(b[i], o);
      check(tag, 32'(o), 32'd0);
    end
  endtask

  task automatic ack_bit(input logic exp_oe, input string tag);
    logic o;
    clk_bit(1'b1, o);
    check(tag, 32'(o), 32'(exp_oe));
  endtask

  task automatic read_byte(input logic [7:0] exp, input string tag);
    logic o;
    logic eb;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, o);
      eb = ~exp[i];
      check(tag, 32'(o), 32'(eb));
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.scl     = 1'b1;
    sda_m       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.tx_data = 8'h00;
    wait_clk(3);
    check("rst_sda_oe",     32'(bus.sda_oe),     32'd0);
    check("rst_rx_data",    32'(bus.rx_data),    32'd0);
    check("rst_rx_valid",   32'(bus.rx_valid),   32'd0);
    check("rst_tx_req",     32'(bus.tx_req),     32'd0);
    check("rst_addr_match", 32'(bus.addr_match), 32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_det_enable", 32'(bus.det_enable), 32'd0);
    rst = 1'b0;
    wait_clk(3);
    check("idle_det_enable", 32'(bus.det_enable), 32'd1);
    check("idle_busy",       32'(bus.busy),       32'd0);

    // 1: matching write of one byte
    oe_cycles = 0;
    bus_start();
    send_bits(8'h84, 8, "t1_addr");
    ack_bit(1'b1, "t1_addr_ack");
    check("t1_addr_match", 32'(bus.addr_match), 32'd1);
    rx_q.push_back(8'hA5);
    send_bits(8'hA5, 8, "t1_data");
    ack_bit(1'b1, "t1_data_ack");
    check("t1_rx_count", 32'(rx_pulses), 32'd1);
    check("t1_addr_match_hold", 32'(bus.addr_match), 32'd1);
    bus_stop("t1");
    check("t1_oe_cycles", 32'(oe_cycles), 32'd80);

    // 2: non-matching address, then eight ignored bits
    oe_cycles = 0;
    bus_start();
    send_bits(8'h86, 8, "t2_addr");
    send_bits(8'h5A, 8, "t2_ignored");
    check("t2_addr_match", 32'(bus.addr_match), 32'd0);
    bus_stop("t2");
    check("t2_oe_cycles", 32'(oe_cycles), 32'd0);
    check("t2_rx_count", 32'(rx_pulses), 32'd1);

    // 3: read two bytes, ACK then NACK
    bus.tx_data = 8'h3C;
    tx_q.push_back(8'h3C);
    bus_start();
    send_bits(8'h85, 8, "t3_addr");
    ack_bit(1'b1, "t3_addr_ack");
    read_byte(8'h3C, "t3_byte1");
    check("t3_tx_count1", 32'(tx_pulses), 32'd1);
    bus.tx_data = 8'hF0;
    tx_q.push_back(8'hF0);
    clk_bit(1'b0, oe);
    check("t3_master_ack", 32'(oe), 32'd0);
    read_byte(8'hF0, "t3_byte2");
    clk_bit(1'b1, oe);
    check("t3_master_nack", 32'(oe), 32'd0);
    check("t3_after_nack", 32'(bus.sda_oe), 32'd0);
    bus_stop("t3");
    check("t3_tx_count2", 32'(tx_pulses), 32'd2);

    // 4: write interrupted by repeated start into a read
    rx_prev = rx_pulses;
    bus_start();
    send_bits(8'h84, 8, "t4_addr");
    ack_bit(1'b1, "t4_addr_ack");
    send_bits(8'hA0, 4, "t4_partial");
    bus.tx_data = 8'h96;
    tx_q.push_back(8'h96);
    bus_rstart(1'b0, "t4_rstart");
    send_bits(8'h85, 8, "t4_addr2");
    ack_bit(1'b1, "t4_addr2_ack");
    check("t4_tx_count", 32'(tx_pulses), 32'd3);
    read_byte(8'h96, "t4_read");
    clk_bit(1'b1, oe);
    check("t4_nack", 32'(oe), 32'd0);
    bus_stop("t4");
    check("t4_no_rx", 32'(rx_pulses), 32'(rx_prev));

    // 5: asynchronous reset during the address ACK, then a normal write
    bus_start();
    send_bits(8'h84, 8, "t5_addr");
    sda_m = 1'b1;
    wait_clk(10);
    bus.scl = 1'b1;
    wait_clk(10);
    check("t5_oe_before_rst", 32'(bus.sda_oe), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_sda_oe",     32'(bus.sda_oe),     32'd0);
    check("t5_async_addr_match", 32'(bus.addr_match), 32'd0);
    check("t5_async_busy",       32'(bus.busy),       32'd0);
    check("t5_async_det_enable", 32'(bus.det_enable), 32'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(20);
    oe_cycles = 0;
    bus_start();
    send_bits(8'h84, 8, "t5b_addr");
    ack_bit(1'b1, "t5b_addr_ack");
    rx_q.push_back(8'h5A);
    send_bits(8'h5A, 8, "t5b_data");
    ack_bit(1'b1, "t5b_data_ack");
    bus_stop("t5b");
    check("t5b_oe_cycles", 32'(oe_cycles), 32'd80);
    check("t5b_rx_count", 32'(rx_pulses), 32'd2);

    // 6: stop after five data bits; then start and stop together
    bus_start();
    send_bits(8'h84, 8, "t6_addr");
    ack_bit(1'b1, "t6_addr_ack");
    send_bits(8'hD8, 5, "t6_partial");
    bus_stop("t6_stop");
    check("t6_no_rx", 32'(rx_pulses), 32'd2);
    bus_start();
    send_bits(8'h84, 8, "t6_addr2");
    ack_bit(1'b1, "t6_addr2_ack");
    send_bits(8'hE0, 3, "t6_partial2");
    bus_rstart(1'b1, "t6_both");
    send_bits(8'h84, 8, "t6_addr3");
    ack_bit(1'b1, "t6_addr3_ack");
    rx_q.push_back(8'hC3);
    send_bits(8'hC3, 8, "t6_data");
    ack_bit(1'b1, "t6_data_ack");
    bus_stop("t6_end");

    check("final_rx_count", 32'(rx_pulses), 32'd3);
    check("final_tx_count", 32'(tx_pulses), 32'd3);
    check("final_rx_queue", 32'(rx_q.size()), 32'd0);
    check("final_tx_queue", 32'(tx_q.size()), 32'd0);
    check("final_det_enable_mismatches", 32'(det_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

- Byte-level sequencer for the I2C slave datapath.
- Consumes single-cycle `start`/`stop` event pulses from the start/stop detectors and the raw `scl`/`sda` lines.
- Tracks address, data and ACK bit phases, and drives the SDA pull-down for ACK and read data.
- Hands received bytes to, and fetches transmit bytes from, the register side through pulse handshakes. It also gates the detectors' `enable`.

## Interface

Parameters:
- `SLAVE_ADDR`, default 7'h42: 7-bit address this slave answers to.
- `SYNC_STAGES`, default 2: flip-flop stages on `scl`/`sda` before edge detection (minimum 2).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `scl` input 1: raw bus clock.
- `sda` input 1: raw bus data (open-drain, resolved).
- `start` input 1: one-cycle pulse from the start detector.
- `stop` input 1: one-cycle pulse from the stop detector.
- `tx_data` input 8: byte to transmit, sampled when `tx_req` is high.
- `det_enable` output 1: enable to the start/stop detectors.
- `sda_oe` output 1: 1 = pull SDA low.
- `rx_data` output 8: last received data byte.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `tx_req` output 1: one-cycle pulse; `tx_data` is latched in that cycle.
- `addr_match` output 1: high from address ACK until IDLE.
- `busy` output 1: state != IDLE.

## Operation

**Synchronisation and edge strobes**
- `scl`/`sda` pass through SYNC_STAGES flip-flops.
- `scl_rise`/`scl_fall` strobes are derived from the last stage and its delayed copy.
- A 3-bit `bit_cnt` counts 0..7, clears on `start` and on every byte boundary.

**States and transitions**
- IDLE: waits for `start`.
- ADDR:
  - Each `scl_rise` shifts synced sda into `shift` (MSB first).
  - On the 8th rise: if `shift[7:1]==SLAVE_ADDR`, latch `rw=shift[0]` and go to ADDR_ACK.
  - Otherwise go to WAIT_STOP.
- ADDR_ACK:
  - Next `scl_fall`: `sda_oe=1`, `addr_match=1`.
  - Following `scl_fall`: if rw=0, `sda_oe=0` and go to RX.
  - If rw=1, go to TX: pulse `tx_req`, set `shift=tx_data` and `sda_oe=~tx_data[7]` in the same cycle.
- RX:
  - 8 `scl_rise` samples.
  - On the 8th: `rx_data<=shift`, pulse `rx_valid`, go to RX_ACK.
- RX_ACK:
  - Next `scl_fall`: `sda_oe=1`.
  - Following `scl_fall`: `sda_oe=0`, go to RX.
  - Every byte is ACKed.
- TX:
  - Each `scl_fall` after the load shifts `shift` left and sets `sda_oe=~shift[6]` (the next bit).
  - After the 8th `scl_rise`, the next `scl_fall` sets `sda_oe=0` and goes to TX_ACK.
- TX_ACK, at `scl_rise`, samples master ACK:
  - 0: the next `scl_fall` reloads exactly as on ADDR_ACK exit (`tx_req` pulse, `sda_oe=~tx_data[7]`) and returns to TX.
  - 1 (NACK): go to WAIT_STOP with `sda_oe=0`.
- WAIT_STOP: ignores the bus until `start` or `stop`.

**Global rules**
- `start` in any state: go to ADDR, `bit_cnt=0`, `sda_oe=0`, `addr_match=0` (repeated start).
- `stop` in any state: go to IDLE, `sda_oe=0`, `addr_match=0`.
- `start` and `stop` in the same cycle: `start` wins.
- `det_enable = ~sda_oe` outside reset. It is 0 during reset.

## Timing

**Reset values**
- State IDLE.
- All outputs 0: `sda_oe`, `rx_data`, `rx_valid`, `tx_req`, `addr_match`, `busy`, `det_enable`.
- `shift`, `bit_cnt` and `rw` are 0.
- Reset mid-transfer releases `sda_oe` asynchronously; there is no wait for a clock edge.

**Latency**
- Raw scl edge to strobe: SYNC_STAGES clk.
- Strobe to registered action (`sda_oe` change, `rx_valid`, `tx_req`, state change): 1 clk.
- Raw edge to output: SYNC_STAGES+1 clk (3 at default).
- `start`/`stop` pulse to state change: 1 clk.

**Pulses and data hold**
- `rx_valid` and `tx_req` are exactly one clk wide.
- `rx_data` holds until the next `rx_valid`.
- `tx_data` must be valid in the `tx_req` cycle; no wait states are supported.

**Output sequencing**
- `sda_oe` changes only in the cycle after `scl_fall`, or on `start`, `stop` or `rst`.
- `bit_cnt` wraps 7→0 at each byte boundary.
- Requirement on `scl`: the SCL high/low phase is at least SYNC_STAGES+2 clk.

## Test plan

All scenarios use clk 50 MHz and an SCL period of 40 clk.

1. Matching write: start, address byte 0x84, data 0xA5, stop.
   - `sda_oe` high for exactly the two 9th-bit low/high windows.
   - One `rx_valid` pulse with `rx_data`=0xA5.
   - `addr_match`=1 until stop; `busy`=0 one clk after `stop`.
2. Non-matching address 0x86, then 8 more SCL clocks, then stop.
   - `sda_oe` never asserts; `addr_match`=0; no `rx_valid`.
   - Block sits in WAIT_STOP, then IDLE.
3. Read: start, address byte 0x85. Byte 1 `tx_data`=0x3C with master ACK; byte 2 `tx_data`=0xF0 with master NACK; stop.
   - Two `tx_req` pulses.
   - `sda_oe` per bit = ~00111100 then ~11110000.
   - `sda_oe`=0 after NACK.
4. Repeated start: write 0x84, 4 data bits, then `start` pulse and address 0x85.
   - No `rx_valid`; `bit_cnt` restarts at 0.
   - Address ACK occurs; `tx_req` fires.
5. `rst` pulsed while `sda_oe`=1 during address ACK.
   - `sda_oe`, `addr_match` and `busy` drop without a clk edge.
   - Subsequent transfer from start works normally.
6. `stop` pulse after 5 data bits, and `start`+`stop` in the same cycle.
   - The stop case goes to IDLE with no `rx_valid`.
   - The simultaneous case goes to ADDR, with `busy`=1.
   - `det_enable`=0 exactly while `sda_oe`=1 throughout.
